// File: rtl/adam_pause_seq_pkg.sv
// Shared state encoding and width helper for the adam_pause_seq pause sequencer.
// Optional timeout detection is enabled by defining ADAM_PAUSE_SEQ_TIMEOUT_EN.
package adam_pause_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT     = 3'd0;
    localparam state_t ST_PAUSED   = 3'd1;
    localparam state_t ST_RES_WAIT = 3'd2;
    localparam state_t ST_RES_GAP  = 3'd3;
    localparam state_t ST_RUNNING  = 3'd4;
    localparam state_t ST_PSE_WAIT = 3'd5;
    localparam state_t ST_PSE_GAP  = 3'd6;

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adam_pause_seq_timer.sv
// Loadable down-counter shared between the inter-step gap and the handshake timeout.
// done is high whenever the count has reached zero; the count saturates there.
module adam_pause_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/adam_pause_seq.sv
// Ordered fan-out of one pause handshake to NO_CHANNELS channels (resume 0..N-1, pause N-1..0).
// Define ADAM_PAUSE_SEQ_TIMEOUT_EN to build the sticky per-step timeout detector.
module adam_pause_seq
    import adam_pause_seq_pkg::*;
#(
    parameter int NO_CHANNELS    = 4,
    parameter int DELAY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pause_req,
    output logic                                pause_ack,
    output logic [NO_CHANNELS-1:0]              ch_req,
    input  logic [NO_CHANNELS-1:0]              ch_ack,
    output logic                                busy,
    output logic                                err,
    output logic [idx_width(NO_CHANNELS)-1:0]   err_ch
);

    localparam int IDX_WIDTH = idx_width(NO_CHANNELS);
`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
`else
    localparam int CNT_MAX = (DELAY_CYCLES > 0) ? DELAY_CYCLES : 1;
`endif
    localparam int CNT_W = idx_width(CNT_MAX + 1);
    localparam bit HAS_GAP = (DELAY_CYCLES > 0);
    // The WAIT->GAP edge already counts as one gap cycle, hence the minus one.
    localparam logic [CNT_W-1:0] GAP_VAL = HAS_GAP ? CNT_W'(DELAY_CYCLES - 1) : '0;
`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] TMO_VAL = '0;
`endif
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NO_CHANNELS - 1);

    state_t                 r_state;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [NO_CHANNELS-1:0] r_ch_req;
    logic                   r_pause_ack;
    logic                   r_busy;

    logic                   w_ack_cur;
    logic [IDX_WIDTH-1:0]   w_idx_up;
    logic [IDX_WIDTH-1:0]   w_idx_dn;
    logic                   w_load;
    logic [CNT_W-1:0]       w_load_val;
    logic                   w_done;

    assign w_ack_cur = ch_ack[r_idx];
    assign w_idx_up  = r_idx + 1'b1;
    assign w_idx_dn  = r_idx - 1'b1;

    // Every WAIT entry arms the timeout, every GAP entry arms the gap delay.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = TMO_VAL;
        case (r_state)
            ST_PAUSED:   w_load = !pause_req;
            ST_RUNNING:  w_load = pause_req;
            ST_RES_WAIT: begin
                if (!w_ack_cur && r_idx != LAST_IDX) begin
                    w_load = 1'b1;
                    if (HAS_GAP) w_load_val = GAP_VAL;
                end
            end
            ST_PSE_WAIT: begin
                if (w_ack_cur && r_idx != '0) begin
                    w_load = 1'b1;
                    if (HAS_GAP) w_load_val = GAP_VAL;
                end
            end
            ST_RES_GAP:  w_load = pause_req || w_done;
            ST_PSE_GAP:  w_load = !pause_req || w_done;
            default:     w_load = 1'b0;
        endcase
    end

    adam_pause_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_ch_req    <= '1;
            r_pause_ack <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (&ch_ack) begin
                        r_state     <= ST_PAUSED;
                        r_pause_ack <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (!pause_req) begin
                        r_idx       <= '0;
                        r_ch_req[0] <= 1'b0;
                        r_state     <= ST_RES_WAIT;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RES_WAIT: begin
                    if (!w_ack_cur) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= ST_RUNNING;
                            r_pause_ack <= 1'b0;
                            r_busy      <= 1'b0;
                        end else if (HAS_GAP) begin
                            r_state <= ST_RES_GAP;
                        end else begin
                            r_idx              <= w_idx_up;
                            r_ch_req[w_idx_up] <= 1'b0;
                        end
                    end
                end
                ST_RES_GAP: begin
                    if (pause_req) begin
                        r_ch_req[r_idx] <= 1'b1;
                        r_state         <= ST_PSE_WAIT;
                    end else if (w_done) begin
                        r_idx              <= w_idx_up;
                        r_ch_req[w_idx_up] <= 1'b0;
                        r_state            <= ST_RES_WAIT;
                    end
                end
                ST_RUNNING: begin
                    if (pause_req) begin
                        r_idx              <= LAST_IDX;
                        r_ch_req[LAST_IDX] <= 1'b1;
                        r_state            <= ST_PSE_WAIT;
                        r_busy             <= 1'b1;
                    end
                end
                ST_PSE_WAIT: begin
                    if (w_ack_cur) begin
                        if (r_idx == '0) begin
                            r_state     <= ST_PAUSED;
                            r_pause_ack <= 1'b1;
                            r_busy      <= 1'b0;
                        end else if (HAS_GAP) begin
                            r_state <= ST_PSE_GAP;
                        end else begin
                            r_idx              <= w_idx_dn;
                            r_ch_req[w_idx_dn] <= 1'b1;
                        end
                    end
                end
                ST_PSE_GAP: begin
                    if (!pause_req) begin
                        r_ch_req[r_idx] <= 1'b0;
                        r_state         <= ST_RES_WAIT;
                    end else if (w_done) begin
                        r_idx              <= w_idx_dn;
                        r_ch_req[w_idx_dn] <= 1'b1;
                        r_state            <= ST_PSE_WAIT;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    logic                 r_err;
    logic [IDX_WIDTH-1:0] r_err_ch;
    logic                 w_waiting;

    assign w_waiting = ((r_state == ST_RES_WAIT) && w_ack_cur) ||
                       ((r_state == ST_PSE_WAIT) && !w_ack_cur);

    // Only the first expiry is recorded; the handshake itself keeps waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err    <= 1'b0;
            r_err_ch <= '0;
        end else if (w_waiting && w_done && !r_err) begin
            r_err    <= 1'b1;
            r_err_ch <= r_idx;
        end
    end

    assign err    = r_err;
    assign err_ch = r_err_ch;
`else
    assign err    = 1'b0;
    assign err_ch = '0;
`endif

    assign ch_req    = r_ch_req;
    assign pause_ack = r_pause_ack;
    assign busy      = r_busy;

endmodule

// File: doc/adam_pause_seq.md
# adam_pause_seq

Synthesizable, parametrised pause sequencer: takes one upstream pause handshake and fans it out to `NO_CHANNELS` downstream pause handshakes in a fixed order. Resume goes channel 0 up to N-1; pause goes N-1 down to 0, with a programmable gap between steps. Optional per-step timeout detection. Sits between the system pause controller and peripheral or core pause ports, replacing ad-hoc behavioural pause drivers in bring-up and power sequencing.

## Interface
- `NO_CHANNELS`, 4: number of downstream pause channels, 1..16.
- `DELAY_CYCLES`, 16: idle cycles between one channel's ack and the next channel's req change; 0 allowed.
- `TIMEOUT_CYCLES`, 1024: cycles a handshake may stay unacknowledged before error; must be ≥1.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pause_req`  in  1  upstream request; 1 = pause all channels, 0 = run.
- `pause_ack`  out  1  1 = all channels paused; 0 = all channels running.
- `ch_req`  out  NO_CHANNELS  per-channel pause request.
- `ch_ack`  in  NO_CHANNELS  per-channel pause acknowledge.
- `busy`  out  1  1 while any step or gap is in progress.
- `err`  out  1  sticky timeout flag.
- `err_ch`  out  $clog2(NO_CHANNELS) (min 1)  channel index of first timeout.

## Operation
- Handshake rule (all ports): a requester changes req only when ack == req; acknowledger follows req. The block never abandons a pending handshake.
- States: INIT, PAUSED, RES_WAIT, RES_GAP, RUNNING, PSE_WAIT, PSE_GAP. Index `idx` selects the active channel.
- INIT (reset): `ch_req` all 1, `pause_ack`=0. Leaves for PAUSED once `&ch_ack`.
- PAUSED: `pause_ack`=1. When `pause_req`=0: `idx`=0, `ch_req[0]`←0, go RES_WAIT.
- RES_WAIT: wait for `ch_ack[idx]`=0.
  - If `idx`=N-1, go RUNNING.
  - Otherwise go RES_GAP and count DELAY_CYCLES; when done, `idx`++, `ch_req[idx]`←0, return to RES_WAIT.
- RUNNING: `pause_ack`=0. When `pause_req`=1: `idx`=N-1, `ch_req[idx]`←1, go PSE_WAIT.
- PSE_WAIT/PSE_GAP: mirror of resume. `idx`-- downward; wait for ack=1. After `idx`=0 is acked, go PAUSED.
- Direction reversal: `pause_req` is sampled only in PAUSED, RUNNING and the GAP states.
  - In RES_GAP with `pause_req`=1: re-pause from the current `idx` downward. The step begins as PSE_WAIT on `idx` with no gap.
  - In PSE_GAP with `pause_req`=0: resume from the current `idx` upward.
  - WAIT states ignore `pause_req` until their ack arrives.
- `pause_ack` changes only on entry to PAUSED (→1) or RUNNING (→0). It holds its value through sequences.
- `busy`=1 in INIT, *_WAIT and *_GAP.

## Timing
- All outputs are registered. Reset values: `ch_req`=all 1, `pause_ack`=0, `busy`=1, `err`=0, `err_ch`=0.
- A `pause_req` change sampled at edge k drives the first `ch_req` change at edge k+1.
- An ack sampled at edge k leads to the next `ch_req` change at edge k+1+DELAY_CYCLES.
- Final ack sampled at k → `pause_ack` updates at k+1.
- Timeout counter restarts on each WAIT entry. It expires after TIMEOUT_CYCLES edges without the ack.
- Asynchronous reset mid-sequence returns to INIT immediately. Counters and `idx` are cleared, `ch_req` is forced to all 1, and `err` is cleared.

## Configuration
- `ADAM_PAUSE_SEQ_TIMEOUT_EN` defined:
  - Timeout counter is present.
  - On expiry, `err`←1 (sticky until reset) and `err_ch`←`idx` of the first failing step; later timeouts do not overwrite it.
  - The sequencer keeps waiting; a timeout never abandons the handshake.
- Undefined: no counter is built; `err`=0 and `err_ch`=0 constantly.

## Structure
- `adam_pause_seq_pkg`: state enum type and the `IDX_WIDTH` derivation function.
- One sub-module, `adam_pause_seq_timer`: a loadable down-counter with a `done` flag. It is shared between the GAP delay and the WAIT timeout, because the two are never active together.

## Test plan
Configuration for all scenarios: NO_CHANNELS=4, DELAY_CYCLES=2, TIMEOUT_CYCLES=8, with macro defined; channel models ack 1 cycle after req.
- Reset release with `ch_ack`=4'b1111 → PAUSED next edge, `pause_ack`=1, `busy`=0.
- `pause_req` 1→0 → `ch_req` clears bit 0, 1, 2, 3 in order, spaced 1+1+2 cycles. `pause_ack`=0 one cycle after `ch_ack[3]`=0.
- From RUNNING, `pause_req`=1 → bits set 3, 2, 1, 0 in order; `pause_ack`=1 after `ch_ack[0]`=1.
- `pause_req`=1 asserted during the RES_GAP after channel 1 resumed → channel 1 then channel 0 re-paused; channels 2 and 3 are never touched.
- Channel 2 model withholds ack for 20 cycles during resume → `err`=1 and `err_ch`=2 exactly 8 cycles after `ch_req[2]` falls. Sequence completes once the ack arrives; `err` stays 1.
- Assert `rst`=0 mid-resume → same-cycle `ch_req`=4'b1111, `pause_ack`=0, `err`=0.
